// File: rtl/zap_ram_fifo_ctrl_if.sv
// FIFO push/pop/status bundle; master drives push and pop, slave is the FIFO.
interface zap_ram_fifo_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             i_clear;
  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_full;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ack;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_clear, i_wr_en, i_wr_data, i_ack,
    input  o_full, o_data, o_valid, o_level, o_overflow, o_underflow
  );

  modport slave (
    input  i_clear, i_wr_en, i_wr_data, i_ack,
    output o_full, o_data, o_valid, o_level, o_overflow, o_underflow
  );
endinterface

// File: rtl/zap_ram_fifo_ctrl.sv
// FWFT FIFO over a 1R1W RAM whose read register is the head; push->head 1 cycle, 1 push + 1 pop/cycle.
// Pushes refused while o_full (no push-through); sticky error flags built only with ZAP_FIFO_ERR_FLAGS_EN.
module zap_ram_fifo_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  zap_ram_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] ram_mem [DEPTH];

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    level_q, level_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]    ram_cnt;
  logic             full;
  logic             push;
  logic             rd;

  always_comb begin
    ram_cnt   = wptr_q - rptr_q;
    full      = (ram_cnt == PW'(DEPTH));
    push      = bus.i_wr_en & ~full & ~bus.i_clear;
    rd        = ~bus.i_clear & (~valid_q | bus.i_ack) & ((ram_cnt != '0) | push);
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    valid_d   = valid_q;
    rd_data_d = rd_data_q;
    if (bus.i_clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (rd) begin
        rptr_d  = rptr_q + PW'(1);
        valid_d = 1'b1;
        // Empty RAM means the read targets the slot being written: forward the push data.
        rd_data_d = (ram_cnt == '0) ? bus.i_wr_data : ram_mem[rptr_q[AW-1:0]];
      end else if (bus.i_ack) begin
        valid_d = 1'b0;
      end
    end
    level_d = (wptr_d - rptr_d) + {{AW{1'b0}}, valid_d};
  end

  always_ff @(posedge i_clk) begin
    if (push) ram_mem[wptr_q[AW-1:0]] <= bus.i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.o_full  = full;
  assign bus.o_data  = rd_data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_level = level_q;

`ifdef ZAP_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.i_wr_en & full);
    udf_d = udf_q | (bus.i_ack & ~valid_q);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
`else
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_zap_ram_fifo_ctrl.sv
// Bench for zap_ram_fifo_ctrl: vector table plus scoreboard queue model of the held words.
module tb_zap_ram_fifo_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic i_clk = 1'b0;
  logic i_reset;

  always #5 i_clk = ~i_clk;

  zap_ram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  zap_ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  typedef struct {
    logic             clr;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic             ak;
    logic             ev;
    logic [WIDTH-1:0] ed;
    int               el;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("valid", 32'(bus.o_valid), 32'(exp_q.size() != 0));
    check("level", 32'(bus.o_level), exp_q.size());
    check("full", 32'(bus.o_full), 32'(exp_q.size() == DEPTH + 1));
    if (exp_q.size() != 0) check("head_data", bus.o_data, exp_q[0]);
`ifdef ZAP_FIFO_ERR_FLAGS_EN
    check("overflow", 32'(bus.o_overflow), 32'(m_ovf));
    check("underflow", 32'(bus.o_underflow), 32'(m_udf));
`else
    check("overflow", 32'(bus.o_overflow), 32'd0);
    check("underflow", 32'(bus.o_underflow), 32'd0);
`endif
  endtask

  // Called on a negedge; drives one cycle of stimulus, updates the model, checks after the edge.
  task automatic step(input logic clr, input logic we, input logic [WIDTH-1:0] wd, input logic ak);
    logic m_full;
    logic m_valid;
    bus.i_clear   = clr;
    bus.i_wr_en   = we;
    bus.i_wr_data = wd;
    bus.i_ack     = ak;
    m_full  = (exp_q.size() == DEPTH + 1);
    m_valid = (exp_q.size() != 0);
    if (we && m_full) m_ovf = 1'b1;
    if (ak && !m_valid) m_udf = 1'b1;
    if (clr) begin
      exp_q.delete();
    end else begin
      if (ak && m_valid) check("pop_data", bus.o_data, exp_q.pop_front());
      if (we && !m_full) exp_q.push_back(wd);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_state();
  endtask

  initial begin
    tbl[0] = '{clr:1'b0, we:1'b1, wd:32'hA5A5_0001, ak:1'b0, ev:1'b1, ed:32'hA5A5_0001, el:1};
    tbl[1] = '{clr:1'b0, we:1'b1, wd:32'h0000_1234, ak:1'b1, ev:1'b1, ed:32'h0000_1234, el:1};
    tbl[2] = '{clr:1'b0, we:1'b1, wd:32'h0000_0002, ak:1'b0, ev:1'b1, ed:32'h0000_1234, el:2};
    tbl[3] = '{clr:1'b0, we:1'b1, wd:32'h0000_0003, ak:1'b0, ev:1'b1, ed:32'h0000_1234, el:3};
    tbl[4] = '{clr:1'b0, we:1'b1, wd:32'h0000_0004, ak:1'b0, ev:1'b1, ed:32'h0000_1234, el:4};
    tbl[5] = '{clr:1'b0, we:1'b1, wd:32'h0000_0005, ak:1'b0, ev:1'b1, ed:32'h0000_1234, el:5};
    tbl[6] = '{clr:1'b1, we:1'b1, wd:32'h0000_0006, ak:1'b0, ev:1'b0, ed:32'h0,         el:0};
    tbl[7] = '{clr:1'b0, we:1'b0, wd:32'h0,         ak:1'b1, ev:1'b0, ed:32'h0,         el:0};
    tbl[8] = '{clr:1'b0, we:1'b0, wd:32'h0,         ak:1'b0, ev:1'b0, ed:32'h0,         el:0};

    i_reset       = 1'b1;
    bus.i_clear   = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_data = '0;
    bus.i_ack     = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_full", 32'(bus.o_full), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("rst_underflow", 32'(bus.o_underflow), 32'd0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].ak);
      check($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d_level", i), 32'(bus.o_level), tbl[i].el);
      if (tbl[i].ev) check($sformatf("vec%0d_data", i), bus.o_data, tbl[i].ed);
    end

    // Fill to capacity, refused pushes at full (with and without ack), then drain in order.
    for (int i = 1; i <= DEPTH + 1; i++) step(1'b0, 1'b1, 32'h1000_0000 + i, 1'b0);
    check("fill_full", 32'(bus.o_full), 32'd1);
    check("fill_level", 32'(bus.o_level), DEPTH + 1);
    step(1'b0, 1'b1, 32'hDEAD_0018, 1'b0);
    check("refused_level", 32'(bus.o_level), DEPTH + 1);
    step(1'b0, 1'b1, 32'hDEAD_0019, 1'b1);
    check("no_push_through", 32'(bus.o_level), DEPTH);
    while (exp_q.size() != 0) step(1'b0, 1'b0, '0, 1'b1);

    // Steady streaming across several pointer wraps.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h2000_0000 + i, 1'b0);
    for (int i = 3; i < 103; i++) step(1'b0, 1'b1, 32'h2000_0000 + i, 1'b1);
    check("stream_level", 32'(bus.o_level), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Randomised traffic: fill-biased then drain-biased, with rare clears.
    for (int i = 0; i < 400; i++) begin
      logic we, ak, clr;
      we  = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ak  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      step(clr, we, $urandom, ak);
    end

    // Clear leaves sticky flags alone.
    step(1'b1, 1'b0, '0, 1'b0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h3000_0000 + i, 1'b0);
    bus.i_wr_en = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check("async_rst_valid", 32'(bus.o_valid), 32'd0);
    check("async_rst_level", 32'(bus.o_level), 32'd0);
    check("async_rst_overflow", 32'(bus.o_overflow), 32'd0);
    check("async_rst_underflow", 32'(bus.o_underflow), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    step(1'b0, 1'b1, 32'h4000_0001, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
